// File: rtl/sl_pkg.sv
// Shared definitions for the SL receiver host controller: receiver field
// positions, register map, interrupt bit positions and config FSM states.
package sl_pkg;

    localparam int unsigned CFG_PCE  = 0;
    localparam int unsigned CFG_BQL  = 1;
    localparam int unsigned CFG_BQH  = 6;
    localparam int unsigned CFG_MODE = 7;
    localparam int unsigned CFG_IRQM = 8;

    localparam int unsigned ST_WLC = 0;
    localparam int unsigned ST_WRP = 1;
    localparam int unsigned ST_WRF = 3;
    localparam int unsigned ST_PEF = 4;
    localparam int unsigned ST_LEF = 5;

    localparam logic [2:0] ADDR_CFG      = 3'd0;
    localparam logic [2:0] ADDR_STAT     = 3'd1;
    localparam logic [2:0] ADDR_DATA     = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [2:0] ADDR_ERR_CNT  = 3'd5;

    localparam int unsigned IRQ_WORD     = 0;
    localparam int unsigned IRQ_ERR      = 1;
    localparam int unsigned IRQ_CFG_DONE = 2;
    localparam int unsigned IRQ_CFG_ERR  = 3;

    localparam logic [15:0] CFG_RST_VAL = 16'h0010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG_REQ,
        S_CFG_DONE,
        S_CFG_FAIL
    } cfg_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/sl_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; DEPTH must be a power
// of two so the pointers wrap naturally.
module sl_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
    assign level = r_cnt;

endmodule

// File: rtl/sl_rx_host_ctrl.sv
// Host-side controller for one SL receiver: register bus, config write
// sequencer, received-word FIFO, line error counters and interrupt.
module sl_rx_host_ctrl
    import sl_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = 16,
    parameter int unsigned STATUS_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CFG_TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bus_sel,
    input  logic                    bus_wr,
    input  logic [2:0]              bus_addr,
    input  logic [31:0]             bus_wdata,
    output logic [31:0]             bus_rdata,
    output logic                    bus_ack,
    output logic                    irq,
    output logic [CONFIG_WIDTH-1:0] rx_wr_config,
    output logic                    rx_wr_enable,
    input  logic [STATUS_WIDTH-1:0] rx_status,
    input  logic [31:0]             rx_data,
    input  logic [CONFIG_WIDTH-1:0] rx_r_config,
    input  logic                    rx_changed
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(CFG_TIMEOUT + 1);

    cfg_state_t              r_state, w_state_nxt;
    logic [CONFIG_WIDTH-1:0] r_cfg;
    logic [TW-1:0]           r_tmo;
    logic                    r_cfg_err, r_ovf;
    logic [3:0]              r_irq_en, r_irq_stat;
    logic [7:0]              r_par, r_len, r_lev;
    logic [STATUS_WIDTH-1:0] r_last_status;

    logic w_rd, w_wr, w_cfg_wr, w_bq_bad, w_cfg_done, w_cfg_fail, w_wr_en;
    logic w_good, w_par, w_len, w_lev, w_push, w_pop, w_ovf, w_err_clr;
    logic w_full, w_empty, w_unused;
    logic [5:0]    w_bq;
    logic [3:0]    w_w1c, w_set;
    logic [LW-1:0] w_level;
    logic [31:0]   w_head, w_rdata;

    assign w_rd     = bus_sel & ~bus_wr;
    assign w_wr     = bus_sel & bus_wr;
    assign w_cfg_wr = w_wr && (bus_addr == ADDR_CFG);
    assign w_bq     = bus_wdata[CFG_BQH:CFG_BQL];
    assign w_bq_bad = (w_bq < 6'd8) || w_bq[0];
    assign w_unused = ^bus_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Match is checked before timeout so a readback arriving on the last cycle still succeeds.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_cfg_done  = 1'b0;
        w_cfg_fail  = 1'b0;
        case (r_state)
            S_IDLE: if (w_cfg_wr) w_state_nxt = w_bq_bad ? S_CFG_FAIL : S_CFG_REQ;
            S_CFG_REQ: begin
                w_wr_en = 1'b1;
                if (rx_r_config == r_cfg)                  w_state_nxt = S_CFG_DONE;
                else if (r_tmo == TW'(CFG_TIMEOUT - 1))    w_state_nxt = S_CFG_FAIL;
            end
            S_CFG_DONE: begin
                w_cfg_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_CFG_FAIL: begin
                w_cfg_fail  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rx_wr_enable = w_wr_en;
    assign rx_wr_config = r_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg     <= CONFIG_WIDTH'(CFG_RST_VAL);
            r_tmo     <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == S_CFG_REQ) ? r_tmo + 1'b1 : '0;
            if (r_state == S_IDLE && w_cfg_wr) begin
                r_cfg     <= bus_wdata[CONFIG_WIDTH-1:0];
                r_cfg_err <= 1'b0;
            end else if (w_cfg_fail) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign w_good = rx_changed & rx_status[ST_WRF] & ~rx_status[ST_WLC] & ~rx_status[ST_PEF];
    assign w_par  = rx_changed & rx_status[ST_WRF] & rx_status[ST_PEF];
    assign w_len  = rx_changed & rx_status[ST_WRF] & rx_status[ST_WLC];
    assign w_lev  = rx_changed & rx_status[ST_LEF];
    assign w_pop  = w_rd && (bus_addr == ADDR_DATA) && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
    assign w_push = w_good && (!w_full || w_pop);
    assign w_ovf  = w_good && w_full && !w_pop;

    sl_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (rx_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_w1c     = (w_wr && bus_addr == ADDR_IRQ_STAT) ? bus_wdata[3:0] : 4'b0;
    assign w_set     = {w_cfg_fail, w_cfg_done, (w_ovf | w_par | w_len | w_lev), w_push};
    assign w_err_clr = w_wr && (bus_addr == ADDR_ERR_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_stat    <= '0;
            r_irq_en      <= '0;
            r_ovf         <= 1'b0;
            r_par         <= '0;
            r_len         <= '0;
            r_lev         <= '0;
            r_last_status <= '0;
            irq           <= 1'b0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_set;
            r_ovf      <= (r_ovf & ~w_w1c[IRQ_ERR]) | w_ovf;
            if (w_wr && bus_addr == ADDR_IRQ_EN) r_irq_en <= bus_wdata[3:0];
            if (rx_changed) r_last_status <= rx_status;
            r_par <= sat_inc(w_err_clr ? 8'h00 : r_par, w_par);
            r_len <= sat_inc(w_err_clr ? 8'h00 : r_len, w_len);
            r_lev <= sat_inc(w_err_clr ? 8'h00 : r_lev, w_lev);
            irq   <= |(r_irq_stat & r_irq_en);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus_addr)
            ADDR_CFG:      w_rdata = 32'(rx_r_config);
            ADDR_STAT:     w_rdata = {16'(r_last_status), 4'b0, rx_status[ST_WRP], r_ovf,
                                      r_cfg_err, (r_state != S_IDLE), 3'b0, 5'(w_level)};
            ADDR_DATA:     w_rdata = w_empty ? 32'h0 : w_head;
            ADDR_IRQ_EN:   w_rdata = {28'b0, r_irq_en};
            ADDR_IRQ_STAT: w_rdata = {28'b0, r_irq_stat};
            ADDR_ERR_CNT:  w_rdata = {8'b0, r_lev, r_len, r_par};
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_sel;
            bus_rdata <= w_rd ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_sl_rx_host_ctrl.sv
// Directed and randomized checks of sl_rx_host_ctrl against a queue-based
// model of the register map, FIFO, counters and config sequencing.
module tb_sl_rx_host_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 1024;
    localparam logic [2:0] A_CFG = 3'd0, A_STAT = 3'd1, A_DATA = 3'd2,
                           A_IEN = 3'd3, A_IST = 3'd4, A_ERR = 3'd5;
    localparam logic [15:0] S_GOOD = 16'h0008, S_PAR = 16'h0018, S_LEN = 16'h0009,
                            S_LEV = 16'h0020, S_START = 16'h0002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_sel, bus_wr;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack, irq;
    logic [15:0] rx_wr_config, rx_status, rx_r_config;
    logic        rx_wr_enable, rx_changed;
    logic [31:0] rx_data;

    sl_rx_host_ctrl #(
        .CONFIG_WIDTH (16),
        .STATUS_WIDTH (16),
        .FIFO_DEPTH   (DEPTH),
        .CFG_TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_sel      (bus_sel),
        .bus_wr       (bus_wr),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .irq          (irq),
        .rx_wr_config (rx_wr_config),
        .rx_wr_enable (rx_wr_enable),
        .rx_status    (rx_status),
        .rx_data      (rx_data),
        .rx_r_config  (rx_r_config),
        .rx_changed   (rx_changed)
    );

    always #5 clk = ~clk;

    // Receiver stand-in: readback follows the written config after match_after enabled cycles.
    int          en_total = 0;
    int          en_base  = 0;
    int          match_after = 0;
    int          arm_id = 0;
    int          hit_id = -1;
    logic [15:0] base_cfg = 16'h0010;
    logic [15:0] hit_val  = 16'h0;

    always @(negedge clk) begin
        if (rx_wr_enable) begin
            en_total = en_total + 1;
            if (match_after != 0 && (en_total - en_base) == match_after) begin
                hit_val = rx_wr_config;
                hit_id  = arm_id;
            end
        end
    end
    assign rx_r_config = (hit_id == arm_id) ? hit_val : base_cfg;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    bit          m_ovf, m_err;
    bit   [3:0]  m_irq, m_en;
    bit   [7:0]  m_par, m_len, m_lev;
    bit   [15:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] sat(input bit [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function void m_clear();
        m_q.delete();
        m_ovf = 0; m_err = 0; m_irq = 0; m_en = 0;
        m_par = 0; m_len = 0; m_lev = 0; m_last = 0;
    endfunction

    function void m_rx(input logic [15:0] s, input logic [31:0] d);
        m_last = s;
        if (s[3] && !s[0] && !s[4]) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
                m_irq[0] = 1;
            end else begin
                m_ovf    = 1;
                m_irq[1] = 1;
            end
        end
        if (s[3] && s[4]) begin m_par = sat(m_par); m_irq[1] = 1; end
        if (s[3] && s[0]) begin m_len = sat(m_len); m_irq[1] = 1; end
        if (s[5])         begin m_lev = sat(m_lev); m_irq[1] = 1; end
    endfunction

    function logic [31:0] m_pop();
        if (m_q.size() == 0) return 32'h0;
        return m_q.pop_front();
    endfunction

    function logic [31:0] exp_stat(input bit busy);
        logic [4:0] lvl;
        lvl = 5'(m_q.size());
        return {m_last, 4'b0, rx_status[1], m_ovf, m_err, busy, 3'b0, lvl};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        bus_sel = 1; bus_wr = 1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 0; bus_wr = 0;
        check("ack_write", 32'(bus_ack), 32'h1);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        bus_sel = 1; bus_wr = 0; bus_addr = a;
        @(negedge clk);
        bus_sel = 0;
        check("ack_read", 32'(bus_ack), 32'h1);
        d = bus_rdata;
    endtask

    task automatic rx_ev(input logic [15:0] s, input logic [31:0] d);
        rx_status = s; rx_data = d; rx_changed = 1;
        @(negedge clk);
        rx_changed = 0; rx_status = 0;
        m_rx(s, d);
    endtask

    task automatic arm(input int after, input logic [15:0] base);
        arm_id      = arm_id + 1;
        en_base     = en_total;
        match_after = after;
        base_cfg    = base;
    endtask

    initial begin
        logic [31:0] d, exp;
        logic [15:0] cfg;
        logic [5:0]  bq;

        rst_n = 0; bus_sel = 0; bus_wr = 0; bus_addr = 0; bus_wdata = 0;
        rx_status = 0; rx_data = 0; rx_changed = 0;
        base_cfg = 16'($urandom);
        m_clear();
        tick(3);
        check("rst_ack", 32'(bus_ack), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_wr_en", 32'(rx_wr_enable), 32'h0);
        check("rst_wr_cfg", 32'(rx_wr_config), 32'h0010);
        rst_n = 1;
        tick(1);
        do_read(A_STAT, d); check("rst_stat", d, 32'h0);
        do_read(A_CFG, d);  check("cfg_readback", d, 32'(base_cfg));
        do_read(A_IST, d);  check("rst_irq_stat", d, 32'h0);
        do_read(A_ERR, d);  check("rst_err_cnt", d, 32'h0);
        do_read(A_DATA, d); check("empty_data", d, m_pop());
        do_read(3'd6, d);   check("unmapped_read", d, 32'h0);

        // Good config: readback follows after 20 enabled cycles.
        arm(20, 16'h0010);
        do_write(A_CFG, 32'h0000_0021);
        check("req_wr_en", 32'(rx_wr_enable), 32'h1);
        check("req_wr_cfg", 32'(rx_wr_config), 32'h0021);
        do_read(A_STAT, d); check("req_busy", d, exp_stat(1));
        tick(40);
        check("good_en_cycles", 32'(en_total - en_base), 32'd20);
        m_irq[2] = 1;
        do_read(A_IST, d);  check("good_irq_stat", d, 32'(m_irq));
        do_read(A_STAT, d); check("good_stat", d, exp_stat(0));
        do_read(A_CFG, d);  check("good_cfg_rd", d, 32'h0021);

        // Bad BQ values fail without a write request.
        arm(0, 16'hFFFF);
        do_write(A_CFG, 32'h0000_000F);
        tick(3);
        check("bq7_no_en", 32'(en_total - en_base), 32'd0);
        m_err = 1; m_irq[3] = 1;
        do_read(A_STAT, d); check("bq7_stat", d, exp_stat(0));
        bq = 6'(9 + 2 * $urandom_range(0, 27));
        do_write(A_CFG, 32'({$urandom_range(0, 511), bq, 1'b1}));
        tick(3);
        check("bq_odd_no_en", 32'(en_total - en_base), 32'd0);
        do_read(A_IST, d);  check("bq_odd_irq_stat", d, 32'(m_irq));

        // Timeout: readback never matches.
        bq  = 6'(8 + 2 * $urandom_range(0, 27));
        cfg = {7'($urandom), 1'b0, bq, 1'($urandom)};
        arm(0, 16'hFFFF);
        do_write(A_CFG, 32'(cfg));
        tick(2);
        do_read(A_STAT, d); m_err = 0; check("tmo_busy", d, exp_stat(1));
        tick(TMO + 40);
        check("tmo_en_cycles", 32'(en_total - en_base), TMO);
        m_err = 1;
        do_read(A_STAT, d); check("tmo_stat", d, exp_stat(0));
        do_write(A_IST, 32'hF); m_irq = 0;
        do_read(A_IST, d);  check("w1c_all", d, 32'h0);

        // Five good words into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) rx_ev(S_GOOD, 32'(i * 32'h11));
        do_read(A_STAT, d); check("ovf_stat", d, exp_stat(0));
        do_read(A_IST, d);  check("ovf_irq_stat", d, 32'(m_irq));
        for (int i = 0; i < 5; i++) begin
            exp = m_pop();
            do_read(A_DATA, d); check("fifo_order", d, exp);
        end
        do_write(A_IST, 32'h2); m_irq[1] = 0; m_ovf = 0;
        rx_status = S_START;
        do_read(A_STAT, d); check("ovf_clr_rx_active", d, exp_stat(0));
        rx_status = 0;

        // Line errors and interrupt masking.
        do_write(A_ERR, 32'h0);
        rx_ev(S_PAR, 32'h0); rx_ev(S_LEN, 32'h0); rx_ev(S_LEV, 32'h0);
        do_read(A_ERR, d); check("err_cnt", d, {8'h0, m_lev, m_len, m_par});
        do_read(A_IST, d); check("err_irq_stat", d, 32'(m_irq));
        check("irq_masked", 32'(irq), 32'h0);
        do_write(A_IEN, 32'h2); m_en = 4'h2;
        tick(1); check("irq_err_en", 32'(irq), 32'(|(m_irq & m_en)));
        do_write(A_IST, 32'h2); m_irq[1] = 0;
        tick(1); check("irq_err_w1c", 32'(irq), 32'(|(m_irq & m_en)));
        m_en = 4'($urandom);
        do_write(A_IEN, 32'(m_en));
        do_read(A_IEN, d); check("irq_en_rd", d, 32'(m_en));

        // Randomized event mix with interleaved pops.
        for (int i = 0; i < 40; i++) begin
            int unsigned k;
            k = $urandom_range(0, 5);
            case (k)
                0, 1:    rx_ev(S_GOOD, $urandom);
                2:       rx_ev(S_PAR, $urandom);
                3:       rx_ev(S_LEN, $urandom);
                4:       rx_ev(S_LEV, $urandom);
                default: rx_ev(S_START, $urandom);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                exp = m_pop();
                do_read(A_DATA, d); check("rnd_data", d, exp);
            end
        end
        tick(1);
        check("rnd_irq", 32'(irq), 32'(|(m_irq & m_en)));
        do_read(A_STAT, d); check("rnd_stat", d, exp_stat(0));
        do_read(A_ERR, d);  check("rnd_err_cnt", d, {8'h0, m_lev, m_len, m_par});
        do_read(A_IST, d);  check("rnd_irq_stat", d, 32'(m_irq));
        while (m_q.size() != 0) begin
            exp = m_pop();
            do_read(A_DATA, d); check("rnd_drain", d, exp);
        end

        // Saturation of the level-error counter, then clear.
        do_write(A_ERR, 32'h0); m_par = 0; m_len = 0; m_lev = 0;
        repeat (257) rx_ev(S_LEV, 32'h0);
        do_read(A_ERR, d);  check("lev_saturate", d, 32'h00FF_0000);
        do_write(A_ERR, 32'hDEAD); m_lev = 0;
        do_read(A_ERR, d);  check("err_clear", d, 32'h0);

        // Push coincident with a pop at full.
        do_write(A_IST, 32'hF); m_irq = 0; m_ovf = 0;
        for (int i = 0; i < DEPTH; i++) rx_ev(S_GOOD, $urandom);
        d = $urandom;
        bus_sel = 1; bus_wr = 0; bus_addr = A_DATA;
        rx_status = S_GOOD; rx_data = d; rx_changed = 1;
        @(negedge clk);
        bus_sel = 0; rx_changed = 0; rx_status = 0;
        exp = m_pop();
        m_rx(S_GOOD, d);
        check("pp_head", bus_rdata, exp);
        do_read(A_STAT, d); check("pp_stat", d, exp_stat(0));
        do_read(A_IST, d);  check("pp_irq_stat", d, 32'(m_irq));
        while (m_q.size() != 0) begin
            exp = m_pop();
            do_read(A_DATA, d); check("pp_drain", d, exp);
        end

        // Asynchronous reset in the middle of a config request.
        arm(0, 16'hFFFF);
        do_write(A_CFG, 32'h0000_0031);
        tick(10);
        check("mid_req_en", 32'(rx_wr_enable), 32'h1);
        #2 rst_n = 0;
        #1 check("async_rst_en", 32'(rx_wr_enable), 32'h0);
        check("async_rst_cfg", 32'(rx_wr_config), 32'h0010);
        tick(2);
        rst_n = 1;
        m_clear();
        en_base = en_total;
        tick(3);
        check("post_rst_no_en", 32'(en_total - en_base), 32'd0);
        do_read(A_STAT, d); check("post_rst_stat", d, exp_stat(0));
        check("post_rst_irq", 32'(irq), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
